// File: rtl/branch_predict_ctrl.sv
// Conditional-branch resolution and 2-bit saturating BHT for the 5-stage RV32I pipe.
// Issues a registered redirect plus IF/ID and ID/EX flushes on mispredict, then skips one wrong-path EX slot.
module branch_predict_ctrl #(
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic        if_is_branch,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic [2:0]  ex_b_control,
    input  logic [31:0] ex_r1,
    input  logic [31:0] ex_r2,
    output logic [2:0]  cmp_b_control,
    output logic [31:0] cmp_r1,
    output logic [31:0] cmp_r2,
    input  logic        cmp_branch_sel,
    input  logic        pipe_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0]  if_idx, ex_idx;
    logic              resolve, actual, mispred, bht_we;
    logic [1:0]        bht_cur, bht_d;
    logic [31:0]       target;
    logic              redirect_d;
    logic [31:0]       redirect_pc_d, br_count_d, mispred_count_d;
    logic              unused_pc_bits;

    assign if_idx         = if_pc[IDX_W+1:2];
    assign ex_idx         = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // IF reads the stored counter; an EX update in the same cycle is not bypassed
    assign if_pred_taken = if_is_branch & bht_q[if_idx][1];
    assign bht_cur       = bht_q[ex_idx];

    assign cmp_b_control = (ex_valid && ex_is_branch && (state_q == IDLE)) ? ex_b_control : 3'b000;
    assign cmp_r1        = ex_r1;
    assign cmp_r2        = ex_r2;

    // Next-state, resolution and update decode
    always_comb begin
        state_d         = state_q;
        redirect_d      = 1'b0;
        redirect_pc_d   = redirect_pc;
        br_count_d      = br_count;
        mispred_count_d = mispred_count;
        bht_we          = 1'b0;
        bht_d           = bht_cur;
        resolve         = 1'b0;
        actual          = ex_is_jump | (ex_is_branch & cmp_branch_sel);
        mispred         = 1'b0;
        target          = actual ? ex_target : ex_pc + 32'd4;
        case (state_q)
            IDLE: begin
                resolve = ex_valid & ~pipe_stall & (ex_is_branch | ex_is_jump);
                mispred = resolve & (actual != ex_pred_taken);
                if (resolve && ex_is_branch && !ex_is_jump) begin
                    bht_we     = 1'b1;
                    br_count_d = br_count + 32'd1;
                    if (actual) bht_d = (bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'd1;
                    else        bht_d = (bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'd1;
                end
                if (mispred) begin
                    state_d         = RECOVER;
                    redirect_d      = 1'b1;
                    redirect_pc_d   = target;
                    mispred_count_d = mispred_count + 32'd1;
                end
            end
            RECOVER: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            br_count       <= 32'd0;
            mispred_count  <= 32'd0;
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else begin
            state_q        <= state_d;
            redirect_valid <= redirect_d;
            redirect_pc    <= redirect_pc_d;
            flush_if_id    <= redirect_d;
            flush_id_ex    <= redirect_d;
            br_count       <= br_count_d;
            mispred_count  <= mispred_count_d;
            if (bht_we) bht_q[ex_idx] <= bht_d;
        end
    end

endmodule
